seg7_scan_controller: RTL and testbench

Time-multiplexed scan controller for the 7-segment display bank. Holds one 8-bit glyph code per digit in an internal buffer, loaded by game logic through a write port, and sequences the single shared glyph decoder across all digits. Each digit slot presents one glyph code and an active-low digit strobe, with an anti-ghost blanking gap at the start of the slot and per-digit blinking. Sits between the score/state logic and the glyph decoder driving the board's segment lines.

---
 rtl/seg7_scan_controller.sv | 136 +++++++++++++
 tb/tb_seg7_scan_controller.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_controller.sv
// seg7_scan_controller
// Time-multiplexed scan of a bank of 7-segment digits through one shared glyph
// decoder. A glyph buffer is written by game logic. Each digit slot is
// SCAN_DIV cycles long and starts with a BLANK_CYC-cycle anti-ghost gap. Masked
// digits blink with a half-period of BLINK_FRAMES full frames.
module seg7_scan_controller #(
  parameter int DIGITS       = 8,
  parameter int SCAN_DIV     = 1000,
  parameter int BLANK_CYC    = 50,
  parameter int BLINK_FRAMES = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [2:0]        wr_addr,
  input  logic [7:0]        wr_glyph,
  input  logic              blink_we,
  input  logic [DIGITS-1:0] blink_mask_in,
  output logic [7:0]        glyph_code,
  output logic [DIGITS-1:0] digit_sel,
  output logic              frame_tick
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(DIGITS);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [DW-1:0] DIV_LAST    = DW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] BLANK_LIM   = DW'(BLANK_CYC);
  localparam logic [IW-1:0] IDX_LAST    = IW'(DIGITS - 1);
  localparam logic [FW-1:0] FR_LAST     = FW'(BLINK_FRAMES - 1);
  localparam logic [7:0]    BLANK_GLYPH = 8'd34;

  logic [DW-1:0]     div_cnt_q, div_cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [FW-1:0]     frame_cnt_q, frame_cnt_d;
  logic              blink_phase_q, blink_phase_d;
  logic [7:0]        glyph_code_q, glyph_code_d;
  logic [DIGITS-1:0] digit_sel_q, digit_sel_d;
  logic              frame_tick_q, frame_tick_d;
  logic [DIGITS-1:0] blink_mask_q;
  logic [7:0]        glyph_buf_q [DIGITS];

  logic          slot_end_s;
  logic          frame_end_s;
  logic [IW-1:0] next_idx_s;
  logic          wr_hit_s;

  // Next-state logic for the scan counters and the registered display outputs.
  always_comb begin
    slot_end_s  = (div_cnt_q == DIV_LAST);
    frame_end_s = slot_end_s && (idx_q == IDX_LAST);
    wr_hit_s    = wr_en && ({1'b0, wr_addr} < 4'(DIGITS));

    if (idx_q == IDX_LAST) begin
      next_idx_s = '0;
    end else begin
      next_idx_s = idx_q + IW'(1);
    end

    if (slot_end_s) begin
      div_cnt_d = '0;
      idx_d     = next_idx_s;
      // Buffer and mask are read before this edge's writes land, so a
      // same-edge write shows on the next visit.
      if (!blink_phase_q && blink_mask_q[next_idx_s]) begin
        glyph_code_d = BLANK_GLYPH;
      end else begin
        glyph_code_d = glyph_buf_q[next_idx_s];
      end
    end else begin
      div_cnt_d    = div_cnt_q + DW'(1);
      idx_d        = idx_q;
      glyph_code_d = glyph_code_q;
    end

    if (frame_end_s) begin
      if (frame_cnt_q == FR_LAST) begin
        frame_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        frame_cnt_d   = frame_cnt_q + FW'(1);
        blink_phase_d = blink_phase_q;
      end
    end else begin
      frame_cnt_d   = frame_cnt_q;
      blink_phase_d = blink_phase_q;
    end

    // Strobe follows the next-state counters so it changes on the same edge
    // as glyph_code and never pairs a digit with another digit's glyph.
    if (div_cnt_d < BLANK_LIM) begin
      digit_sel_d = '1;
    end else begin
      digit_sel_d = ~(DIGITS'(1) << idx_d);
    end

    frame_tick_d = frame_end_s;
  end

  // State registers, glyph buffer and blink mask with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt_q     <= '0;
      idx_q         <= '0;
      frame_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
      glyph_code_q  <= BLANK_GLYPH;
      digit_sel_q   <= '1;
      frame_tick_q  <= 1'b0;
      blink_mask_q  <= '0;
      for (int i = 0; i < DIGITS; i++) begin
        glyph_buf_q[i] <= BLANK_GLYPH;
      end
    end else begin
      div_cnt_q     <= div_cnt_d;
      idx_q         <= idx_d;
      frame_cnt_q   <= frame_cnt_d;
      blink_phase_q <= blink_phase_d;
      glyph_code_q  <= glyph_code_d;
      digit_sel_q   <= digit_sel_d;
      frame_tick_q  <= frame_tick_d;
      if (wr_hit_s) begin
        glyph_buf_q[wr_addr[IW-1:0]] <= wr_glyph;
      end
      if (blink_we) begin
        blink_mask_q <= blink_mask_in;
      end
    end
  end

  assign glyph_code = glyph_code_q;
  assign digit_sel  = digit_sel_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_controller.sv
// Bench for seg7_scan_controller: two instances (anti-ghost gap 1 and 0) share
// the stimulus. A cycle-time model derives every expected output from the
// elapsed time since reset and pushes it into a queue; a monitor on the
// falling edge pops and compares.
module tb_seg7_scan_controller;

  localparam int D  = 4;
  localparam int SD = 4;
  localparam int BC = 1;
  localparam int BF = 2;
  localparam int FRAME = D * SD;

  logic         clk;
  logic         rst_n;
  logic         wr_en;
  logic [2:0]   wr_addr;
  logic [7:0]   wr_glyph;
  logic         blink_we;
  logic [D-1:0] blink_mask_in;
  logic [7:0]   glyph_code,  glyph_code0;
  logic [D-1:0] digit_sel,   digit_sel0;
  logic         frame_tick,  frame_tick0;

  seg7_scan_controller #(.DIGITS(D), .SCAN_DIV(SD), .BLANK_CYC(BC), .BLINK_FRAMES(BF)) u_dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_glyph(wr_glyph),
    .blink_we(blink_we), .blink_mask_in(blink_mask_in),
    .glyph_code(glyph_code), .digit_sel(digit_sel), .frame_tick(frame_tick)
  );

  seg7_scan_controller #(.DIGITS(D), .SCAN_DIV(SD), .BLANK_CYC(0), .BLINK_FRAMES(BF)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_glyph(wr_glyph),
    .blink_we(blink_we), .blink_mask_in(blink_mask_in),
    .glyph_code(glyph_code0), .digit_sel(digit_sel0), .frame_tick(frame_tick0)
  );

  typedef struct {
    int glyph;
    int sel;
    int sel0;
    int tick;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passed = 0;

  // model state
  int   t;
  int   mbuf [D];
  logic [D-1:0] mmask;
  int   cur_glyph;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got %0d expected %0d (model t=%0d, time %0t)", name, act, exp, t, $time);
    end
  endtask

  // Reference model: time since reset decides slot, digit and frame.
  initial begin
    exp_t e;
    t = 0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        t = 0;
        for (int i = 0; i < D; i++) mbuf[i] = 34;
        mmask = '0;
        cur_glyph = 34;
        e.glyph = 34;
        e.sel   = (1 << D) - 1;
        e.sel0  = (1 << D) - 1;
        e.tick  = 0;
      end else begin
        int pos, slot, frame, nd;
        bit shown;
        pos   = t % SD;
        slot  = t / SD;
        frame = slot / D;
        if (pos == SD - 1) begin
          nd    = (slot + 1) % D;
          shown = ((frame / BF) % 2) == 0;
          cur_glyph = (!shown && mmask[nd]) ? 34 : mbuf[nd];
        end
        if (wr_en && wr_addr < D) mbuf[wr_addr] = wr_glyph;
        if (blink_we) mmask = blink_mask_in;
        t++;
        pos  = t % SD;
        nd   = (t / SD) % D;
        e.glyph = cur_glyph;
        e.sel   = (pos < BC) ? ((1 << D) - 1) : (~(1 << nd) & ((1 << D) - 1));
        e.sel0  = ~(1 << nd) & ((1 << D) - 1);
        e.tick  = (pos == 0 && nd == 0 && t >= FRAME) ? 1 : 0;
      end
      q.push_back(e);
    end
  end

  // Monitor: compare every presented cycle against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("glyph_code", int'(glyph_code), e.glyph);
        chk("digit_sel", int'(digit_sel), e.sel);
        chk("frame_tick", int'(frame_tick), e.tick);
        chk("glyph_code_nogap", int'(glyph_code0), e.glyph);
        chk("digit_sel_nogap", int'(digit_sel0), e.sel0);
        chk("frame_tick_nogap", int'(frame_tick0), e.tick);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wr(input int a, input int g);
    wr_en    = 1'b1;
    wr_addr  = 3'(a);
    wr_glyph = 8'(g);
    step(1);
    wr_en    = 1'b0;
  endtask

  // Advance until the next edge is the one where model time mod FRAME == m.
  task automatic wait_t(input int m);
    int n;
    n = 0;
    while ((t % FRAME) != m && n < 4 * FRAME) begin
      step(1);
      n++;
    end
    chk("wait_t_bound", (n < 4 * FRAME) ? 1 : 0, 1);
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = 3'd0; wr_glyph = 8'd0;
    blink_we = 1'b0; blink_mask_in = '0;
    step(3);
    rst_n = 1'b1;
    step(20);

    // fresh reset, then load 1..4 before the first wrap
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    wr(0, 1); wr(1, 2); wr(2, 3); wr(3, 4);
    step(2 * FRAME);

    // write digit 2 on its exact latch edge, then an out-of-range address
    wait_t(7);
    wr(2, 9);
    wr(5, 77);
    step(3 * FRAME);

    // blink digit 1 showing 7
    wr(1, 7);
    blink_we = 1'b1; blink_mask_in = 4'b0010;
    step(1);
    blink_we = 1'b0;
    step(7 * FRAME);

    // one-cycle reset in the middle of slot 2
    wait_t(9);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(2 * FRAME);

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      wr_en         = ($urandom % 4) == 0;
      wr_addr       = 3'($urandom % 8);
      wr_glyph      = 8'($urandom);
      blink_we      = ($urandom % 32) == 0;
      blink_mask_in = 4'($urandom);
      rst_n         = ($urandom % 300) != 0;
      step(1);
    end
    wr_en = 1'b0; blink_we = 1'b0; rst_n = 1'b1;
    step(5);
    @(negedge clk);
    #1;
    chk("enough_checks", (checks >= 12) ? 1 : 0, 1);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
